rotate_seq_ctrl: RTL
====================

Name: rotate_seq_ctrl

Overview:
- Sequencing controller for the 64-line × 25-bit rotate datapath.
- On `start` it runs two phases. READ issues credit-limited reads of all 64 source lines and steers each returned line into the datapath capture buffer. WRITE streams the 64 rotated result lines back to memory under ready backpressure.
- Sits between the top-level sequencer (start/done) and the shared line memory plus rotate datapath. It replaces ad-hoc counter enables with a single FSM and handshakes.

Parameters:
- `DEPTH`, 64, number of lines per operation (must be a power of 2).
- `ADDR_W`, 6, log2(`DEPTH`); width of address/index buses.
- `MAX_OUT`, 2, maximum outstanding memory reads (1..7).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin an operation; sampled only in IDLE.
- `mem_rd_en`  out  1  read request, one line per cycle asserted.
- `mem_addr`  out  `ADDR_W`  read address in READ, write address in WRITE.
- `mem_rd_valid`  in  1  read data returned (in issue order, latency ≥1).
- `mem_wr_en`  out  1  write request; held until accepted.
- `mem_wr_ready`  in  1  write accepted when `mem_wr_en` && `mem_wr_ready`.
- `dp_cap_en`  out  1  capture `line_in` into datapath buffer slot `dp_cap_idx`.
- `dp_cap_idx`  out  `ADDR_W`  capture slot = returned-line index.
- `dp_out_sel`  out  `ADDR_W`  output line index the datapath drives on `write_value`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at end of operation.
- `err`  out  1  sticky: `mem_rd_valid` with zero reads outstanding.

Behaviour:
- Reset (`rst`=0, asynchronous): state=IDLE; all counters=0; `mem_rd_en`=0, `mem_wr_en`=0, `dp_cap_en`=0, `busy`=0, `done`=0, `err`=0; `mem_addr`/`dp_cap_idx`/`dp_out_sel`=0.
- Reset mid-operation aborts immediately, with no `done`. Read data returning after reset deassertion while in IDLE sets `err`.
- Counters (`ADDR_W`+1 bits each, so `DEPTH` is representable):
  - `iss_cnt`: reads issued.
  - `cap_cnt`: lines captured.
  - `out_cnt`: lines written.
  - `outstanding` (3 bits).
- States:
  - IDLE: `start`=1 → READ; clear counters and `err`. Otherwise stay.
  - READ:
    - `mem_rd_en`=1 iff `iss_cnt`<`DEPTH` and `outstanding`<`MAX_OUT`, with `mem_addr`=`iss_cnt`[`ADDR_W`-1:0]. An issue increments `iss_cnt`.
    - `mem_rd_valid` → `dp_cap_en`=1 combinationally in the same cycle, `dp_cap_idx`=`cap_cnt`; `cap_cnt`++.
    - `outstanding` += issue − return. A simultaneous issue and return leaves it unchanged.
    - When `cap_cnt` reaches `DEPTH` (the registered count after the 64th capture) → WRITE.
  - WRITE:
    - `mem_wr_en`=1, `mem_addr`=`dp_out_sel`=`out_cnt`[`ADDR_W`-1:0].
    - On `mem_wr_ready`: `out_cnt`++. If `out_cnt`=`DEPTH`−1 → DONE.
    - With `mem_wr_ready` low, address and `mem_wr_en` are held stable.
  - DONE: `done`=1 for exactly one cycle, `busy`=1; → IDLE.
- `start` outside IDLE is ignored (no queueing). `start` held high across DONE→IDLE begins a new operation on the following cycle.
- `mem_rd_valid` outside READ, or with `outstanding`=0: no capture, `err` set (sticky until next accepted `start`), counters unchanged.
- Minimum latency:
  - Read latency 1, `MAX_OUT`≥2, write ready always high: READ = 65 cycles (64 issues, last return 1 cycle later), WRITE = 64 cycles, plus DONE.
  - Total: `start` to `done` = 1 + 65 + 64 + 1 cycles. `done` is asserted in cycle 131 after `start` is sampled.
- Read issue never exceeds `DEPTH`. Address wraps are impossible because counters stop at `DEPTH`.

Decomposition:
- Shared package `rotate_pkg`: state encoding constants (IDLE=0, READ=1, WRITE=2, DONE=3), `DEPTH`/`ADDR_W` defaults.
- One natural sub-module, `rd_credit_tracker`: owns `outstanding`, `iss_cnt` and `cap_cnt`, plus the issue-allowed and error logic.
- FSM, write counter and output muxing remain in `rotate_seq_ctrl`.

Test Plan:
- Latency-1 memory, `mem_wr_ready`=1, `start` pulse → 64 `mem_rd_en` on addresses 0..63 consecutively; 64 `dp_cap_en` with idx 0..63; 64 writes on addresses 0..63; single `done` 131 cycles after `start`; `busy` low afterwards.
- Read latency 4, `MAX_OUT`=2 → never more than 2 reads outstanding (checker on issue−return count); captures remain in order 0..63; `done` still a single pulse.
- `mem_wr_ready` random 50% during WRITE → `mem_addr`/`mem_wr_en` stable while stalled; exactly 64 accepted writes, addresses 0..63, no duplicates.
- Assert `rst`=0 at write 30, then release; spurious `mem_rd_valid` in IDLE → outputs at reset values, no `done`; `err`=1 and remaining set until the next `start`.
- `start` pulsed during READ and held through DONE → mid-op pulse ignored; second operation begins the cycle after returning to IDLE and completes with its own `done`.

Source files
------------

// File: rtl/rotate_pkg.sv
// Shared definitions for the rotate sequencing controller.
//   - state_t     : controller phase encoding (IDLE/READ/WRITE/DONE)
//   - *_DEF       : default geometry of the 64-line rotate datapath
//   - OUT_W       : width of the outstanding-read counter (MAX_OUT <= 7)
package rotate_pkg;

  localparam int DEPTH_DEF   = 64;
  localparam int ADDR_W_DEF  = 6;
  localparam int MAX_OUT_DEF = 2;
  localparam int OUT_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rd_credit_tracker.sv
// Read-side bookkeeping for the rotate sequencer: issue/capture counters,
// outstanding-read credit and the sticky protocol-error flag.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   clear        : start accepted; zero all counters and the error flag
//   rd_phase     : controller is in its READ phase
//   rd_valid     : memory returned a line this cycle
//   issue        : a read is issued this cycle
//   cap_en       : the returned line is captured this cycle
//   last_cap     : this capture is the final line of the operation
//   err          : sticky, a return arrived with no read outstanding
//   iss_addr     : address of the read being issued
//   cap_idx      : buffer slot for the line being captured
module rd_credit_tracker
  import rotate_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int MAX_OUT = MAX_OUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              rd_phase,
  input  logic              rd_valid,
  output logic              issue,
  output logic              cap_en,
  output logic              last_cap,
  output logic              err,
  output logic [ADDR_W-1:0] iss_addr,
  output logic [ADDR_W-1:0] cap_idx
);

  logic [ADDR_W:0]  iss_cnt;
  logic [ADDR_W:0]  cap_cnt;
  logic [OUT_W-1:0] outstanding;
  logic             ret_ok;

  // Credit check uses the registered count, so a return in the same cycle
  // does not free a slot until the next cycle.
  assign issue    = rd_phase && (iss_cnt < (ADDR_W+1)'(DEPTH))
                    && (outstanding < OUT_W'(MAX_OUT));
  assign ret_ok   = rd_phase && rd_valid && (outstanding != '0);
  assign cap_en   = ret_ok;
  assign last_cap = ret_ok && (cap_cnt == (ADDR_W+1)'(DEPTH-1));
  assign iss_addr = iss_cnt[ADDR_W-1:0];
  assign cap_idx  = cap_cnt[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iss_cnt     <= '0;
      cap_cnt     <= '0;
      outstanding <= '0;
      err         <= 1'b0;
    end else if (clear) begin
      iss_cnt     <= '0;
      cap_cnt     <= '0;
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      if (issue)  iss_cnt <= iss_cnt + 1'b1;
      if (ret_ok) cap_cnt <= cap_cnt + 1'b1;
      case ({issue, ret_ok})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      // Any return that cannot be matched to an outstanding read is a
      // protocol violation, including returns outside the READ phase.
      if (rd_valid && !ret_ok) err <= 1'b1;
    end
  end

endmodule

// File: rtl/rotate_seq_ctrl.sv
// Sequencing controller for the line-rotate datapath. On start it reads all
// DEPTH source lines (credit limited), steering each into the capture buffer,
// then streams DEPTH rotated lines back to memory under write backpressure.
// Ports:
//   clk, rst               : clock, asynchronous active-low reset
//   start                  : begin an operation (honoured only when idle)
//   mem_rd_en / mem_rd_valid : read request / in-order read return
//   mem_wr_en / mem_wr_ready : write request (held) / write accept
//   mem_addr               : read address in READ, write address in WRITE
//   dp_cap_en / dp_cap_idx : capture strobe and slot for returned line
//   dp_out_sel             : line index the datapath drives for writing
//   busy, done, err        : status; done is a one-cycle pulse, err sticky
module rotate_seq_ctrl
  import rotate_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int MAX_OUT = MAX_OUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rd_valid,
  output logic              mem_wr_en,
  input  logic              mem_wr_ready,
  output logic              dp_cap_en,
  output logic [ADDR_W-1:0] dp_cap_idx,
  output logic [ADDR_W-1:0] dp_out_sel,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   out_cnt;
  logic              accept_start;
  logic              wr_fire;
  logic              issue;
  logic              last_cap;
  logic [ADDR_W-1:0] iss_addr;

  assign accept_start = (state == ST_IDLE) && start;
  assign wr_fire      = (state == ST_WRITE) && mem_wr_ready;

  rd_credit_tracker #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .MAX_OUT (MAX_OUT)
  ) u_rd_credit_tracker (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept_start),
    .rd_phase (state == ST_READ),
    .rd_valid (mem_rd_valid),
    .issue    (issue),
    .cap_en   (dp_cap_en),
    .last_cap (last_cap),
    .err      (err),
    .iss_addr (iss_addr),
    .cap_idx  (dp_cap_idx)
  );

  assign dp_out_sel = out_cnt[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      out_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept_start)  out_cnt <= '0;
      else if (wr_fire)  out_cnt <= out_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ST_READ;
      end
      ST_READ: begin
        mem_rd_en = issue;
        mem_addr  = iss_addr;
        // Leave READ in the cycle of the final capture so the captured
        // count is already DEPTH on entry to WRITE.
        if (last_cap) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        mem_wr_en = 1'b1;
        mem_addr  = out_cnt[ADDR_W-1:0];
        if (mem_wr_ready && (out_cnt == (ADDR_W+1)'(DEPTH-1)))
          state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
